// File: rtl/vrf_pkg.sv
// Shared definitions for the vector register file writeback path.
// Holds register index and vector types plus the round-robin wrap helper.
package vrf_pkg;

    localparam int VREG_IDX_W = 5;
    localparam int NUM_VREGS  = 32;
    localparam int VEC_WIDTH  = 16;
    localparam int GRANT_ID_W = 2;

    typedef logic [VREG_IDX_W-1:0] vreg_idx_t;
    typedef logic [VEC_WIDTH-1:0][VEC_WIDTH-1:0] vec_t;

    // Wraps idx (which is below 2*n) back into the range 0..n-1.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/vrf_wb_arbiter_if.sv
// Bus bundle for vrf_wb_arbiter: writeback requests, register-file write
// port, and the destination reservation / hazard lookup port.
interface vrf_wb_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 2
);
    import vrf_pkg::*;

    logic [NREQ-1:0]                  req_valid;
    logic [NREQ-1:0]                  req_ready;
    vreg_idx_t [NREQ-1:0]             req_rd;
    logic [NREQ-1:0][WIDTH*WIDTH-1:0] req_wd;

    logic                             rf_wev;
    vreg_idx_t                        rf_rd;
    logic [WIDTH*WIDTH-1:0]           rf_wd;
    logic [GRANT_ID_W-1:0]            grant_id;

    logic                             issue_valid;
    vreg_idx_t                        issue_rd;
    logic                             issue_ready;
    vreg_idx_t                        rs1;
    vreg_idx_t                        rs2;
    vreg_idx_t                        rs3;
    logic                             hazard;

    // Requesters and decoder side.
    modport master (
        output req_valid, req_rd, req_wd, issue_valid, issue_rd, rs1, rs2, rs3,
        input  req_ready, rf_wev, rf_rd, rf_wd, grant_id, issue_ready, hazard
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_rd, req_wd, issue_valid, issue_rd, rs1, rs2, rs3,
        output req_ready, rf_wev, rf_rd, rf_wd, grant_id, issue_ready, hazard
    );

endinterface

// File: rtl/vrf_wb_arbiter_rr.sv
// rr_arbiter: round-robin selector. The first requester at or after the
// pointer wins; the pointer moves to one past the winner after each grant.
// Grants are forced off while rst_n is low.
module rr_arbiter
    import vrf_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    output logic [NREQ-1:0]       grant,
    output logic [GRANT_ID_W-1:0] grant_idx,
    output logic                  grant_any
);

    logic [GRANT_ID_W-1:0] rr_ptr_reg;
    logic [GRANT_ID_W-1:0] rr_ptr_next;
    logic [GRANT_ID_W-1:0] sel_idx;
    logic                  sel_found;
    int                    cand;

    // Scan from the pointer; iterating from the far end lets the nearest valid requester win.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        cand      = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = rr_wrap(int'(rr_ptr_reg) + k, NREQ);
            if (req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = GRANT_ID_W'(cand);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : gen_grant
            assign grant[gi] = rst_n & sel_found & (sel_idx == GRANT_ID_W'(gi));
        end
    endgenerate

    assign grant_any = rst_n & sel_found;
    assign grant_idx = sel_idx;

    // Next pointer: one past the winner on a grant, otherwise unchanged.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant_any) begin
            rr_ptr_next = (sel_idx == GRANT_ID_W'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

endmodule

// File: rtl/vrf_wb_arbiter.sv
// vrf_wb_arbiter: arbitrates NREQ vector writebacks onto one registered
// register-file write port (one cycle latency, one write per cycle).
// Optional destination scoreboard enabled by the macro
// VRF_WB_ARBITER_SCOREBOARD_EN; without it hazard=0 and issue_ready=1.
module vrf_wb_arbiter
    import vrf_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREQ  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    vrf_wb_arbiter_if.slave  bus
);

    logic [NREQ-1:0]        grant;
    logic [GRANT_ID_W-1:0]  grant_idx;
    logic                   grant_any;

    vreg_idx_t              sel_rd;
    logic [WIDTH*WIDTH-1:0] sel_wd;

    logic                   rf_wev_reg;
    vreg_idx_t              rf_rd_reg;
    logic [WIDTH*WIDTH-1:0] rf_wd_reg;
    logic [GRANT_ID_W-1:0]  grant_id_reg;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.req_valid),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign bus.req_ready = grant;

    // Route the winning requester's destination and data (grant is one-hot or zero).
    always_comb begin
        sel_rd = '0;
        sel_wd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_rd = bus.req_rd[i];
                sel_wd = bus.req_wd[i];
            end
        end
    end

    // Register-file write port: capture the winner, otherwise pulse off and hold data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_wev_reg   <= 1'b0;
            rf_rd_reg    <= '0;
            rf_wd_reg    <= '0;
            grant_id_reg <= '0;
        end else if (grant_any) begin
            rf_wev_reg   <= 1'b1;
            rf_rd_reg    <= sel_rd;
            rf_wd_reg    <= sel_wd;
            grant_id_reg <= grant_idx;
        end else begin
            rf_wev_reg   <= 1'b0;
        end
    end

    assign bus.rf_wev   = rf_wev_reg;
    assign bus.rf_rd    = rf_rd_reg;
    assign bus.rf_wd    = rf_wd_reg;
    assign bus.grant_id = grant_id_reg;

`ifdef VRF_WB_ARBITER_SCOREBOARD_EN
    logic [NUM_VREGS-1:0] busy_reg;
    logic [NUM_VREGS-1:0] busy_next;
    logic                 issue_ready_w;
    logic                 issue_fire;

    assign issue_ready_w = ~busy_reg[bus.issue_rd];
    assign issue_fire    = bus.issue_valid & issue_ready_w;

    // Per register: a reservation sets, a visible write clears, and set beats clear.
    generate
        for (genvar gi = 0; gi < NUM_VREGS; gi++) begin : gen_busy
            assign busy_next[gi] = (issue_fire && (bus.issue_rd == VREG_IDX_W'(gi)))
                                 | (busy_reg[gi] & ~(rf_wev_reg && (rf_rd_reg == VREG_IDX_W'(gi))));
        end
    endgenerate

    // Busy bit register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign bus.issue_ready = issue_ready_w;
    assign bus.hazard      = busy_reg[bus.rs1] | busy_reg[bus.rs2] | busy_reg[bus.rs3];
`else
    logic unused_sb_inputs;

    assign unused_sb_inputs = ^{bus.issue_valid, bus.issue_rd, bus.rs1, bus.rs2, bus.rs3};
    assign bus.issue_ready  = 1'b1;
    assign bus.hazard       = 1'b0;
`endif

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Randomized scoreboard bench for vrf_wb_arbiter with a directed prologue
// (reset, single requester, contention, reservations, mid-write reset).
module tb_vrf_wb_arbiter;
    import vrf_pkg::*;

    localparam int WIDTH = 16;
    localparam int NREQ  = 2;
    localparam int VW    = WIDTH * WIDTH;
    localparam int NCYC  = 1500;
`ifdef VRF_WB_ARBITER_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    typedef struct {
        logic          wev;
        logic [4:0]    rd;
        logic [VW-1:0] wd;
        logic [1:0]    gid;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vrf_wb_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    vrf_wb_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state.
    int            m_ptr;
    bit [31:0]     m_busy;
    exp_t          m_rf;
    bit            known;
    bit            pend_v  [NREQ];
    logic [4:0]    pend_rd [NREQ];
    logic [VW-1:0] pend_wd [NREQ];

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic set_req(input int i, input int rd, input logic [VW-1:0] wd);
        pend_v[i]  = 1'b1;
        pend_rd[i] = 5'(rd);
        pend_wd[i] = wd;
    endtask

    task automatic gen_stim(input int cyc);
        logic [VW-1:0] a5;
        a5 = {16{16'hA5A5}};
        rst_n           = 1'b1;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.rs1         = '0;
        bus.rs2         = '0;
        bus.rs3         = '0;
        if (cyc < 2) begin
            rst_n = 1'b0;
            for (int i = 0; i < NREQ; i++) set_req(i, $urandom_range(31), rand_vec());
            bus.issue_valid = 1'b1;
            bus.issue_rd    = 5'($urandom_range(31));
            bus.rs1         = 5'($urandom_range(31));
        end else if (cyc == 2) begin
            set_req(0, 5, a5);
        end else if (cyc == 3) begin
            rst_n = 1'b0;
        end else if (cyc <= 11) begin
            for (int i = 0; i < 2; i++)
                if (!pend_v[i]) set_req(i, $urandom_range(31, 10), rand_vec());
        end else if (cyc == 12) begin
            bus.issue_valid = 1'b1;
            bus.issue_rd    = 5'd7;
        end else if (cyc == 13) begin
            bus.issue_valid = 1'b1;
            bus.issue_rd    = 5'd7;
            bus.rs2         = 5'd7;
        end else if (cyc == 14) begin
            set_req(0, 7, rand_vec());
            bus.rs2 = 5'd7;
        end else if (cyc <= 16) begin
            bus.rs2 = 5'd7;
        end else if (cyc == 17) begin
            set_req(0, 9, rand_vec());
        end else if (cyc == 18) begin
            bus.issue_valid = 1'b1;
            bus.issue_rd    = 5'd9;
            bus.rs1         = 5'd9;
        end else if (cyc == 19) begin
            bus.rs1 = 5'd9;
        end else if (cyc == 20) begin
            set_req(0, 3, rand_vec());
            bus.issue_valid = 1'b1;
            bus.issue_rd    = 5'd11;
        end else if (cyc == 21) begin
            rst_n = 1'b0;
            set_req(1, 4, rand_vec());
            bus.issue_valid = 1'b1;
            bus.issue_rd    = 5'd12;
        end else if (cyc == 22) begin
            bus.rs1 = 5'd9;
            bus.rs2 = 5'd11;
            bus.rs3 = 5'd12;
        end else begin
            rst_n = ($urandom_range(63) != 0);
            for (int i = 0; i < NREQ; i++)
                if (!pend_v[i] && $urandom_range(1) == 1) set_req(i, $urandom_range(7), rand_vec());
            bus.issue_valid = 1'($urandom_range(1));
            bus.issue_rd    = 5'($urandom_range(7));
            bus.rs1         = 5'($urandom_range(7));
            bus.rs2         = 5'($urandom_range(7));
            bus.rs3         = 5'($urandom_range(7));
        end
    endtask

    // Checks combinational outputs against the model and returns the expected write-port state.
    task automatic model_step(output exp_t nx);
        logic [NREQ-1:0] exp_ready;
        bit [31:0]       nb;
        int              w;
        int              c;
        exp_ready = '0;
        w = -1;
        if (rst_n) begin
            for (int k = 0; k < NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (w < 0 && pend_v[c]) w = c;
            end
        end
        if (w >= 0) exp_ready[w] = 1'b1;
        check("req_ready", VW'(bus.req_ready), VW'(exp_ready));
        if (known) begin
            check("hazard", VW'(bus.hazard),
                  VW'(SB_EN && (m_busy[bus.rs1] || m_busy[bus.rs2] || m_busy[bus.rs3])));
            check("issue_ready", VW'(bus.issue_ready), VW'(!(SB_EN && m_busy[bus.issue_rd])));
        end
        if (!rst_n) begin
            nx     = '{1'b0, 5'd0, '0, 2'd0};
            m_ptr  = 0;
            m_busy = '0;
        end else begin
            nb = m_busy;
            if (SB_EN) begin
                if (m_rf.wev) nb[m_rf.rd] = 1'b0;
                if (bus.issue_valid && !m_busy[bus.issue_rd]) nb[bus.issue_rd] = 1'b1;
            end
            m_busy = nb;
            if (w >= 0) begin
                nx        = '{1'b1, pend_rd[w], pend_wd[w], 2'(w)};
                m_ptr     = (w + 1) % NREQ;
                pend_v[w] = 1'b0;
            end else begin
                nx     = m_rf;
                nx.wev = 1'b0;
            end
        end
        m_rf = nx;
    endtask

    // Stimulus and model: one iteration per clock cycle.
    initial begin
        exp_t nx;
        m_ptr  = 0;
        m_busy = '0;
        m_rf   = '{1'b0, 5'd0, '0, 2'd0};
        known  = 1'b0;
        for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc > 0 && !rst_n)
                for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
            gen_stim(cyc);
            for (int i = 0; i < NREQ; i++) begin
                bus.req_valid[i] = pend_v[i];
                bus.req_rd[i]    = pend_rd[i];
                bus.req_wd[i]    = pend_wd[i];
            end
            #1;
            model_step(nx);
            @(posedge clk);
            exp_q.push_back(nx);
            known = 1'b1;
            #1;
        end
        @(negedge clk);
        #1;
        check("queue_drained", VW'(exp_q.size()), VW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Monitor: each falling edge compares the write port with the expectation for the last rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rf_wev", VW'(bus.rf_wev), VW'(e.wev));
                check("rf_rd", VW'(bus.rf_rd), VW'(e.rd));
                check("rf_wd", bus.rf_wd, e.wd);
                check("grant_id", VW'(bus.grant_id), VW'(e.gid));
            end
        end
    end

endmodule

// File: doc/vrf_wb_arbiter.md
VRF_WB_ARBITER -- requirements
Module: vrf_wb_arbiter

Interface
REQ-001 Parameter WIDTH, default 16: lanes per vector and bits per lane; each vector is WIDTH x WIDTH bits.
REQ-002 Parameter NREQ, default 2: number of writeback requesters, legal range 2..4.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  NREQ  requester i has a vector writeback pending.
REQ-006 req_ready  out  NREQ  requester i's writeback is accepted this cycle.
REQ-007 req_rd  in  NREQx5  destination vector register of requester i.
REQ-008 req_wd  in  NREQxWIDTHxWIDTH  write data of requester i.
REQ-009 rf_wev  out  1  registered write enable to the vector register file.
REQ-010 rf_rd  out  5  registered destination index to the vector register file.
REQ-011 rf_wd  out  WIDTHxWIDTH  registered write data to the vector register file.
REQ-012 grant_id  out  2  registered index of the requester that drives the current rf_* write.
REQ-013 issue_valid  in  1  the decoder requests a reservation of destination issue_rd.
REQ-014 issue_rd  in  5  destination register to reserve.
REQ-015 issue_ready  out  1  the reservation is accepted this cycle.
REQ-016 rs1, rs2, rs3  in  5 each  source indices of the instruction being decoded.
REQ-017 hazard  out  1  at least one source register has a pending, unwritten result.

Function
REQ-018 Arbitration SHALL be round-robin: starting from pointer rr_ptr, the first i (mod NREQ) with req_valid[i]=1 wins.
REQ-019 req_ready SHALL be combinational and one-hot or zero: asserted only for the winner, and never for a requester with req_valid=0.
REQ-020 A transfer SHALL occur when req_valid[i] and req_ready[i] are both 1; the requester holds rd and wd stable until that transfer.
REQ-021 After a transfer by requester i, rr_ptr SHALL become (i+1) mod NREQ; with no transfer, rr_ptr holds.
REQ-022 The latency SHALL be exactly 1 cycle: on the next edge, rf_wev=1, and rf_rd, rf_wd and grant_id hold the winner's values.
REQ-023 In a cycle with no transfer, rf_wev SHALL be 0 on the next edge, and rf_rd, rf_wd and grant_id SHALL hold their values.
REQ-024 Throughput SHALL be one write per cycle; with all requesters continuously valid, each is granted at least once every NREQ cycles.
REQ-025 Scoreboard: busy[31:0]; issue_valid & issue_ready sets busy[issue_rd]; rf_wev=1 clears busy[rf_rd] at the same edge.
REQ-026 issue_ready SHALL equal !busy[issue_rd], so no second reservation is accepted while a write to that register is pending.
REQ-027 When a set and a clear target the same register in one cycle, the set SHALL win and busy stays 1.
REQ-028 hazard SHALL equal busy[rs1] | busy[rs2] | busy[rs3], combinationally.
REQ-029 A writeback to a register whose busy bit is 0 SHALL be performed normally and leave busy unchanged.

Reset
REQ-030 While rst_n=0 at an edge, the following SHALL be forced: rf_wev=0, rf_rd=0, rf_wd=0, grant_id=0, rr_ptr=0, busy=0.
REQ-031 During reset, req_ready SHALL be all 0, and reservations and writes presented in reset cycles are discarded.
REQ-032 A reset asserted mid-operation SHALL drop any in-flight write, and the first possible grant is in the cycle after rst_n returns to 1.

Configuration
REQ-033 Macro VRF_WB_ARBITER_SCOREBOARD_EN defined: the scoreboard in REQ-025..REQ-029 is implemented.
REQ-034 Macro undefined: there is no busy state, hazard=0, issue_ready=1, and arbitration is unchanged.

Structure
REQ-035 Shared package vrf_pkg SHALL hold:
- VREG_IDX_W=5
- NUM_VREGS=32
- typedef vreg_idx_t (5 bits)
- typedef vec_t (WIDTH x WIDTH packed, default 16)
REQ-036 The round-robin selection SHALL be one sub-module, rr_arbiter (NREQ-wide request in, one-hot grant out, pointer update).

Verification
REQ-037 Reset: drive rst_n=0 for 2 cycles with all inputs active -> rf_wev=0, hazard=0, req_ready=0, and busy=0 after release.
REQ-038 Single requester: req0 valid, rd=5, wd=all 16'hA5A5 -> ready0 same cycle, and next cycle rf_wev=1, rf_rd=5, rf_wd=A5A5s, grant_id=0.
REQ-039 Contention: req0 and req1 valid continuously from reset -> grants alternate 0,1,0,1 and rf_wev=1 every cycle.
REQ-040 Scoreboard: reserve rd=7, then set rs2=7 -> hazard=1 and issue_ready=0 for rd=7; after the writeback to 7 is visible on rf_*, hazard=0 on the following cycle.
REQ-041 Same-cycle set and clear: issue_rd=9 while rf_wev=1 and rf_rd=9 -> busy[9] stays 1.
REQ-042 Reset mid-write: assert rst_n=0 on the cycle after a grant -> rf_wev=0 at the next edge, and busy is cleared.
